// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helper functions for the serial pattern detector
package seq_det_pkg;

    localparam logic [3:0] DEF_PATTERN = 4'b1101;

    function automatic int prefix_w(input int pw);
        return $clog2(pw + 1);
    endfunction

    // Longest k whose newest k history bits equal the first k pattern bits.
    function automatic int prefix_len_calc(
        input logic [31:0] h,
        input logic [31:0] p,
        input int          pw,
        input int          fill
    );
        int          best;
        logic [32:0] mask;
        best = 0;
        for (int k = 32; k >= 1; k--) begin
            mask = (33'd1 << k) - 33'd1;
            if (best == 0 && k <= pw && k <= fill &&
                ((h & mask[31:0]) == ((p >> (pw - k)) & mask[31:0])))
                best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - qualified serial bit stream into the detector
interface seq_detector_param_if;
    logic in_valid;
    logic in_bit;

    modport master (output in_valid, output in_bit);
    modport slave  (input  in_valid, input  in_bit);
endinterface

// File: rtl/seq_prefix_match.sv
// rtl/seq_prefix_match.sv - combinational full-match and matched-prefix evaluation
module seq_prefix_match
    import seq_det_pkg::*;
#(
    parameter int PATTERN_W = 4,
    parameter int PW_W      = prefix_w(PATTERN_W)
) (
    input  logic [PATTERN_W-1:0] hist_next,
    input  logic [PW_W-1:0]      fill_next,
    input  logic [PATTERN_W-1:0] pat,
    output logic                 full_match,
    output logic [PW_W-1:0]      prefix_len_next
);

    assign full_match = (fill_next == PW_W'(PATTERN_W)) && (hist_next == pat);

    assign prefix_len_next = PW_W'(prefix_len_calc(32'(hist_next), 32'(pat),
                                                   PATTERN_W, int'(fill_next)));

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable serial pattern detector with saturating match count
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W   = 4,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = PATTERN_W'(DEF_PATTERN),
    parameter int                   CNT_W       = 8,
    parameter int                   PW_W        = prefix_w(PATTERN_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 pattern_load,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic                 overlap,
    seq_detector_param_if.slave  bits,
    output logic                 match,
    output logic [PW_W-1:0]      prefix_len,
    output logic [CNT_W-1:0]     match_count
);

    logic [PATTERN_W-1:0] hist_q, hist_d, hist_shift;
    logic [PATTERN_W-1:0] pat_q, pat_d;
    logic [PW_W-1:0]      fill_q, fill_d, fill_inc;
    logic [PW_W-1:0]      plen_q, plen_d, plen_calc;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 match_q, match_d;
    logic                 full_match;

    assign hist_shift = {hist_q[PATTERN_W-2:0], bits.in_bit};
    assign fill_inc   = (fill_q == PW_W'(PATTERN_W)) ? fill_q : fill_q + 1'b1;

    seq_prefix_match #(
        .PATTERN_W (PATTERN_W),
        .PW_W      (PW_W)
    ) u_prefix (
        .hist_next       (hist_shift),
        .fill_next       (fill_inc),
        .pat             (pat_q),
        .full_match      (full_match),
        .prefix_len_next (plen_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN_RST;
            plen_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            plen_q  <= plen_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    // clear > pattern_load > in_valid; a lower-priority event in the same cycle is dropped
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        plen_d  = plen_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
            plen_d = '0;
            cnt_d  = '0;
        end else if (pattern_load) begin
            pat_d  = pattern_in;
            hist_d = '0;
            fill_d = '0;
            plen_d = '0;
        end else if (bits.in_valid) begin
            match_d = full_match;
            if (full_match && cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + 1'b1;
            if (full_match && !overlap) begin
                hist_d = '0;
                fill_d = '0;
                plen_d = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_inc;
                plen_d = plen_calc;
            end
        end
    end

    assign match       = match_q;
    assign prefix_len  = plen_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param (8-bit and 2-bit counters)
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       pattern_load = 1'b0;
    logic [3:0] pattern_in = 4'd0;
    logic       overlap = 1'b1;

    logic       match_a, match_b;
    logic [2:0] plen_a, plen_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    seq_detector_param_if bus_a ();
    seq_detector_param_if bus_b ();

    seq_detector_param #(.PATTERN_W(4), .PATTERN_RST(4'b1101), .CNT_W(8)) dut_a (
        .clk (clk), .rst_n (rst_n), .clear (clear), .pattern_load (pattern_load),
        .pattern_in (pattern_in), .overlap (overlap), .bits (bus_a.slave),
        .match (match_a), .prefix_len (plen_a), .match_count (cnt_a)
    );

    seq_detector_param #(.PATTERN_W(4), .PATTERN_RST(4'b1101), .CNT_W(2)) dut_b (
        .clk (clk), .rst_n (rst_n), .clear (clear), .pattern_load (pattern_load),
        .pattern_in (pattern_in), .overlap (overlap), .bits (bus_b.slave),
        .match (match_b), .prefix_len (plen_b), .match_count (cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [2:0] pl;
        logic [7:0] c;
        logic [1:0] c2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;

    logic [3:0] m_hist, m_pat;
    int         m_fill, m_plen, m_cnt, m_cnt2;
    logic       m_match;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = 4'd0; m_pat = 4'b1101; m_fill = 0; m_plen = 0;
        m_cnt = 0; m_cnt2 = 0; m_match = 1'b0;
    endtask

    function automatic int ref_prefix(input logic [3:0] h, input int f, input logic [3:0] p);
        int  best;
        bit  ok;
        best = 0;
        for (int k = 4; k >= 1; k--) begin
            if (best == 0 && k <= f) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (h[j] != p[4-k+j]) ok = 1'b0;
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    task automatic model(input logic clr, input logic ld, input logic [3:0] pin,
                         input logic ovl, input logic v, input logic b);
        logic [3:0] nh;
        int         nf;
        logic       full;
        m_match = 1'b0;
        if (clr) begin
            m_hist = 4'd0; m_fill = 0; m_plen = 0; m_cnt = 0; m_cnt2 = 0;
        end else if (ld) begin
            m_pat = pin; m_hist = 4'd0; m_fill = 0; m_plen = 0;
        end else if (v) begin
            nh = {m_hist[2:0], b};
            nf = (m_fill < 4) ? m_fill + 1 : 4;
            full = (nf == 4) && (nh == m_pat);
            m_match = full;
            if (full && m_cnt < 255) m_cnt++;
            if (full && m_cnt2 < 3) m_cnt2++;
            if (full && !ovl) begin
                m_hist = 4'd0; m_fill = 0; m_plen = 0;
            end else begin
                m_hist = nh; m_fill = nf; m_plen = ref_prefix(nh, nf, m_pat);
            end
        end
    endtask

    // drive one cycle, push the model's prediction, compare after the edge
    task automatic step(input logic clr, input logic ld, input logic [3:0] pin,
                        input logic ovl, input logic v, input logic b);
        exp_t e, got;
        clear = clr; pattern_load = ld; pattern_in = pin; overlap = ovl;
        bus_a.in_valid = v; bus_a.in_bit = b;
        bus_b.in_valid = v; bus_b.in_bit = b;
        model(clr, ld, pin, ovl, v, b);
        e.m = m_match; e.pl = 3'(m_plen); e.c = 8'(m_cnt); e.c2 = 2'(m_cnt2);
        sb.push_back(e);
        @(posedge clk);
        #1;
        clear = 1'b0; pattern_load = 1'b0;
        bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
        got = sb.pop_front();
        if (match_a) pulses++;
        chk("match_a", 32'(match_a), 32'(got.m));
        chk("match_b", 32'(match_b), 32'(got.m));
        chk("plen_a", 32'(plen_a), 32'(got.pl));
        chk("plen_b", 32'(plen_b), 32'(got.pl));
        chk("cnt_a", 32'(cnt_a), 32'(got.c));
        chk("cnt_b", 32'(cnt_b), 32'(got.c2));
    endtask

    task automatic send(input logic [31:0] seq, input int n, input logic ovl, input int max_gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b0, 4'd0, ovl, 1'b1, seq[i]);
            if (max_gap > 0 && i > 0) begin
                int g;
                g = $urandom_range(max_gap, 1);
                for (int j = 0; j < g; j++) step(1'b0, 1'b0, 4'd0, ovl, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_bit = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_bit = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match", 32'(match_a), 32'd0);
        chk("rst_plen", 32'(plen_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pulses = 0;
        send(32'b1101101, 7, 1'b1, 0);
        chk("ovl_pulses", 32'(pulses), 32'd2);
        chk("ovl_cnt", 32'(cnt_a), 32'd2);

        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        send(32'b1101101, 7, 1'b0, 0);
        chk("novl_pulses", 32'(pulses), 32'd1);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        send(32'b11011101, 8, 1'b0, 0);
        chk("novl2_pulses", 32'(pulses), 32'd2);

        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        send(32'b1101, 4, 1'b1, 3);
        chk("gap_pulses", 32'(pulses), 32'd1);

        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        send(32'b1101101101, 10, 1'b1, 0);
        chk("pre_load_cnt", 32'(cnt_a), 32'd3);
        step(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
        chk("load_plen", 32'(plen_a), 32'd0);
        send(32'b0110, 4, 1'b1, 0);
        chk("load_cnt", 32'(cnt_a), 32'd4);

        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        send(32'b11111111, 8, 1'b1, 0);
        chk("sat_pulses", 32'(pulses), 32'd5);
        chk("sat_cnt_b", 32'(cnt_b), 32'd3);
        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("clr_cnt_b", 32'(cnt_b), 32'd0);

        send(32'b111, 3, 1'b1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_plen", 32'(plen_a), 32'd0);
        chk("arst_match", 32'(match_a), 32'd0);
        chk("arst_cnt", 32'(cnt_a), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        send(32'b1101, 4, 1'b1, 0);
        chk("arst_pat_pulses", 32'(pulses), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
